// File: rtl/data_mem_periph.sv
// data_mem_periph -- MEM stage of the pipelined MIPS core.
// 256-word data RAM plus memory-mapped LEDs, switches, 7-seg display and an
// optional 32-bit reload timer with level interrupt.
//
// Optional feature macro: PERIPH_TIMER_EN (defined -> TH/TL/TCON timer present;
// undefined -> timer addresses read 0, writes ignored, oIRQ tied low).
//
// Ports:
//   clk        pipeline clock, rising edge
//   reset      async active-low, clears peripheral registers (not RAM)
//   iMemRead   load in MEM stage      iMemWrite  store in MEM stage
//   iAddr      byte address (bits [1:0] ignored)
//   iWriteData store data             iSwitch    board switches
//   oReadData  combinational load data (0 when iMemRead=0)
//   oLED       LED register           oDigi      {anode[3:0], seg[7:0]}
//   oIRQ       timer interrupt, level
//
// Map: 0x000-0x3FF RAM; 0x40000000 TH, +4 TL, +8 TCON{irq,ien,ten},
//      +C LED, +10 switches (RO), +14 Digi.
module data_mem_periph #(
  parameter int RAM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [31:0] iAddr,
  input  logic [31:0] iWriteData,
  input  logic [7:0]  iSwitch,
  output logic [31:0] oReadData,
  output logic [7:0]  oLED,
  output logic [11:0] oDigi,
  output logic        oIRQ
);
  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] mem [RAM_WORDS];
  logic        ram_hit, per_hit;
  logic        sel_th, sel_tl, sel_tcon, sel_led, sel_sw, sel_digi;
  logic [1:0]  unused_addr;

  assign unused_addr = iAddr[1:0];

  assign ram_hit  = (iAddr[31:10] == 22'd0);
  assign per_hit  = (iAddr[31:5] == 27'h200_0000);
  assign sel_th   = per_hit && (iAddr[4:2] == 3'd0);
  assign sel_tl   = per_hit && (iAddr[4:2] == 3'd1);
  assign sel_tcon = per_hit && (iAddr[4:2] == 3'd2);
  assign sel_led  = per_hit && (iAddr[4:2] == 3'd3);
  assign sel_sw   = per_hit && (iAddr[4:2] == 3'd4);
  assign sel_digi = per_hit && (iAddr[4:2] == 3'd5);

  // RAM: no reset, contents survive the peripheral reset.
  always_ff @(posedge clk) begin
    if (iMemWrite && ram_hit) mem[iAddr[AW+1:2]] <= iWriteData;
  end

  // LED / Digi registers
  logic [7:0]  led_q, led_d;
  logic [11:0] digi_q, digi_d;

  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (iMemWrite && sel_led)  led_d  = iWriteData[7:0];
    if (iMemWrite && sel_digi) digi_d = iWriteData[11:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      led_q  <= led_d;
      digi_q <= digi_d;
    end
  end

  assign oLED  = led_q;
  assign oDigi = digi_q;

  // Timer
  logic [31:0] th_rd, tl_rd;
  logic [2:0]  tcon_rd;

`ifdef PERIPH_TIMER_EN
  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf_set;

  always_comb begin
    th_d    = th_q;
    tl_d    = tl_q;
    tcon_d  = tcon_q;
    ovf_set = 1'b0;
    if (tcon_q[0]) begin
      if (tl_q == 32'hFFFF_FFFF) begin
        tl_d    = th_q;
        ovf_set = tcon_q[1];
      end else begin
        tl_d = tl_q + 32'd1;
      end
    end
    if (ovf_set) tcon_d[2] = 1'b1;
    // CPU writes override the timer, except the status bit keeps a
    // same-cycle overflow so an interrupt is never dropped.
    if (iMemWrite && sel_th)   th_d   = iWriteData;
    if (iMemWrite && sel_tl)   tl_d   = iWriteData;
    if (iMemWrite && sel_tcon) tcon_d = {iWriteData[2] | ovf_set, iWriteData[1:0]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_rd   = th_q;
  assign tl_rd   = tl_q;
  assign tcon_rd = tcon_q;
  assign oIRQ    = tcon_q[2] & tcon_q[1];
`else
  assign th_rd   = '0;
  assign tl_rd   = '0;
  assign tcon_rd = '0;
  assign oIRQ    = 1'b0;
`endif

  // Read mux: reflects pre-write state, so read+write returns the old value.
  always_comb begin
    oReadData = '0;
    if (iMemRead) begin
      if (ram_hit)       oReadData = mem[iAddr[AW+1:2]];
      else if (sel_th)   oReadData = th_rd;
      else if (sel_tl)   oReadData = tl_rd;
      else if (sel_tcon) oReadData = {29'd0, tcon_rd};
      else if (sel_led)  oReadData = {24'd0, led_q};
      else if (sel_sw)   oReadData = {24'd0, iSwitch};
      else if (sel_digi) oReadData = {20'd0, digi_q};
    end
  end
endmodule
